// File: rtl/sprite_ram_arbiter.sv
// Single-port sprite RAM arbiter: the sprite datapath always owns the port when it
// reads; CPU accesses are slotted into free cycles through a req/ack handshake.
module sprite_ram_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int MAX_WAIT    = 64,
    parameter int LOCK_VBLANK = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vblank,
    input  logic              spr_rd_en,
    input  logic [ADDR_W-1:0] spr_addr,
    output logic [DATA_W-1:0] spr_din,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    output logic              cpu_starved,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_RD  = 2'd1,
        CPU_GAP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                spr_tag_q;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [DATA_W-1:0]   cpu_rdata_q;
    logic                cpu_grant;
    logic                vblank_block;
    logic                rd_return;

    assign vblank_block = (LOCK_VBLANK != 0) && vblank;
    assign cpu_grant    = rst_n && (state_q == IDLE) && cpu_req && !spr_rd_en && !vblank_block;
    assign cpu_ack      = cpu_grant;

    // The CPU read data is on ram_dout during CPU_RD; present it immediately and
    // keep a registered copy so the value holds until the next read completes.
    assign rd_return    = rst_n && (state_q == CPU_RD);
    assign cpu_rvalid   = rd_return;
    assign cpu_rdata    = rd_return ? ram_dout : cpu_rdata_q;

    assign spr_din      = spr_tag_q ? ram_dout : '0;
    assign cpu_starved  = (wait_q == WAIT_MAX);

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (rst_n && spr_rd_en) begin
            ram_en   = 1'b1;
            ram_addr = spr_addr;
        end else if (cpu_grant) begin
            ram_en    = 1'b1;
            ram_we    = cpu_we;
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            IDLE: begin
                if (cpu_grant) begin
                    state_d = cpu_we ? CPU_GAP : CPU_RD;
                end
            end
            CPU_RD:  state_d = IDLE;
            CPU_GAP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Starvation counter only observes the CPU side; it never blocks the sprite.
        if (cpu_grant || !cpu_req) begin
            wait_d = '0;
        end else if (wait_q != WAIT_MAX) begin
            wait_d = wait_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            spr_tag_q   <= 1'b0;
            wait_q      <= '0;
            cpu_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            spr_tag_q <= spr_rd_en;
            wait_q    <= wait_d;
            if (rd_return) begin
                cpu_rdata_q <= ram_dout;
            end
        end
    end

endmodule

// File: tb/tb_sprite_ram_arbiter.sv
// Bench for sprite_ram_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_sprite_ram_arbiter;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int MW     = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              vblank = 1'b0;
    logic              spr_rd_en = 1'b0;
    logic [ADDR_W-1:0] spr_addr = '0;
    logic [DATA_W-1:0] spr_din;
    logic              cpu_req = 1'b0;
    logic              cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rvalid;
    logic              cpu_starved;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_dout = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sprite_ram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MW), .LOCK_VBLANK(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .vblank(vblank),
        .spr_rd_en(spr_rd_en), .spr_addr(spr_addr), .spr_din(spr_din),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .cpu_starved(cpu_starved),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_dout(ram_dout)
    );

    function automatic logic [7:0] preload(input int i);
        logic [7:0] b;
        b = 8'(i);
        return (i < 8) ? 8'h10 + b : b + 8'h33;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural sprite RAM (4K deep, address aliased on the low 12 bits).
    logic [7:0] ram [0:4095];
    logic       ram_loaded = 1'b0;
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 4096; i++) ram[i] <= preload(i);
            ram_loaded <= 1'b1;
        end else if (ram_en) begin
            if (ram_we) ram[ram_addr[11:0]] <= ram_wdata;
            else        ram_dout <= ram[ram_addr[11:0]];
        end
    end

    // Transaction-level reference: port ownership, ack spacing, return data, wait count.
    logic [7:0] mmem [0:4095];
    int         cyc = 0;
    int         last_ack = -100;
    bit         rd_pend = 0, spr_pend = 0;
    logic [7:0] rd_val = '0, spr_val = '0, rhold = '0;
    int         wcnt = 0;

    initial for (int i = 0; i < 4096; i++) mmem[i] = preload(i);

    always @(negedge clk) begin
        bit         g;
        bit         e_en, e_we;
        logic [15:0] e_addr;
        logic [7:0]  e_wd;
        if (!rst_n) begin
            chk("m_rst_ack", 32'(cpu_ack), 32'd0);
            chk("m_rst_ram", {ram_en, ram_we, ram_wdata, ram_addr}, 32'd0);
            chk("m_rst_rvalid", 32'(cpu_rvalid), 32'd0);
            last_ack = -100; rd_pend = 0; spr_pend = 0; wcnt = 0; rhold = '0;
        end else begin
            g = cpu_req && !spr_rd_en && (cyc - last_ack >= 2) && !vblank;
            e_en = spr_rd_en || g;
            e_we = !spr_rd_en && g && cpu_we;
            e_addr = spr_rd_en ? spr_addr : (g ? cpu_addr : 16'h0);
            e_wd = (!spr_rd_en && g) ? cpu_wdata : 8'h0;
            chk("m_ack", 32'(cpu_ack), 32'(g));
            chk("m_ram_en_we", {30'd0, ram_en, ram_we}, {30'd0, e_en, e_we});
            chk("m_ram_addr", 32'(ram_addr), 32'(e_addr));
            chk("m_ram_wdata", 32'(ram_wdata), 32'(e_wd));
            chk("m_spr_din", 32'(spr_din), spr_pend ? 32'(spr_val) : 32'd0);
            chk("m_rvalid", 32'(cpu_rvalid), 32'(rd_pend));
            chk("m_rdata", 32'(cpu_rdata), rd_pend ? 32'(rd_val) : 32'(rhold));
            chk("m_starved", 32'(cpu_starved), 32'(wcnt == MW));
            if (rd_pend) rhold = rd_val;
            spr_pend = spr_rd_en;
            if (spr_rd_en) spr_val = mmem[spr_addr[11:0]];
            rd_pend = g && !cpu_we;
            if (g && !cpu_we) rd_val = mmem[cpu_addr[11:0]];
            if (g && cpu_we) mmem[cpu_addr[11:0]] = cpu_wdata;
            if (g) last_ack = cyc;
            if (g || !cpu_req) wcnt = 0;
            else if (wcnt < MW) wcnt = wcnt + 1;
        end
        cyc++;
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    function automatic logic [15:0] rand_addr();
        return ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 63));
    endfunction

    initial begin
        bit ack_seen;
        int vb_left;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        smp();
        chk("rst_spr_din", 32'(spr_din), 32'd0);
        chk("rst_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("rst_starved", 32'(cpu_starved), 32'd0);
        chk("rst_rdata", 32'(cpu_rdata), 32'd0);
        chk("rst_ram_en", 32'(ram_en), 32'd0);
        nxt();

        // Sprite burst over 0..7
        for (int i = 0; i < 9; i++) begin
            spr_rd_en = (i < 8);
            spr_addr = 16'(i);
            smp();
            if (i < 8) begin
                chk("burst_we", 32'(ram_we), 32'd0);
                chk("burst_addr", 32'(ram_addr), 32'(i));
            end
            if (i > 0) chk("burst_din", 32'(spr_din), 32'(8'h10 + i - 1));
            nxt();
        end

        // CPU write then read
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0123; cpu_wdata = 8'hA5;
        smp();
        chk("wr_ack", 32'(cpu_ack), 32'd1);
        chk("wr_ram_we", 32'(ram_we), 32'd1);
        chk("wr_ram_addr", 32'(ram_addr), 32'h0123);
        chk("wr_ram_wdata", 32'(ram_wdata), 32'hA5);
        nxt();
        smp();
        chk("wr_gap_ack", 32'(cpu_ack), 32'd0);
        nxt();
        cpu_req = 1'b0;
        smp();
        nxt();
        cpu_req = 1'b1; cpu_we = 1'b0;
        smp();
        chk("rd_ack", 32'(cpu_ack), 32'd1);
        nxt();
        cpu_req = 1'b0;
        smp();
        chk("rd_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("rd_rdata", 32'(cpu_rdata), 32'hA5);
        nxt();

        // Contention with a 5-cycle sprite run
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040;
        for (int i = 0; i < 5; i++) begin
            spr_rd_en = 1'b1; spr_addr = 16'(i);
            smp();
            chk("con_ack", 32'(cpu_ack), 32'd0);
            if (i > 0) chk("con_din", 32'(spr_din), 32'(8'h10 + i - 1));
            nxt();
        end
        spr_rd_en = 1'b0;
        smp();
        chk("con_ack6", 32'(cpu_ack), 32'd1);
        chk("con_din_last", 32'(spr_din), 32'h14);
        nxt();
        cpu_req = 1'b0;
        smp();
        chk("con_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("con_rdata", 32'(cpu_rdata), 32'h73);
        nxt();

        // Overlap of CPU read return and sprite read
        cpu_req = 1'b1; cpu_addr = 16'h0005;
        smp();
        chk("ov_ack", 32'(cpu_ack), 32'd1);
        nxt();
        cpu_req = 1'b0; spr_rd_en = 1'b1; spr_addr = 16'h0006;
        smp();
        chk("ov_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("ov_rdata", 32'(cpu_rdata), 32'h15);
        chk("ov_ram_addr", 32'(ram_addr), 32'h0006);
        nxt();
        spr_rd_en = 1'b0;
        smp();
        chk("ov_din", 32'(spr_din), 32'h16);
        chk("ov_hold", 32'(cpu_rdata), 32'h15);
        nxt();

        // Starvation under the vblank lock
        vblank = 1'b1; cpu_req = 1'b1; cpu_addr = 16'h0002;
        for (int i = 0; i < 5; i++) begin
            smp();
            chk("st_ack", 32'(cpu_ack), 32'd0);
            chk("st_starved", 32'(cpu_starved), 32'(i == 4));
            nxt();
        end
        vblank = 1'b0;
        smp();
        chk("st_ack_release", 32'(cpu_ack), 32'd1);
        chk("st_starved_hold", 32'(cpu_starved), 32'd1);
        nxt();
        cpu_req = 1'b0;
        smp();
        chk("st_starved_clear", 32'(cpu_starved), 32'd0);
        chk("st_rdata", 32'(cpu_rdata), 32'h12);
        nxt();

        // Reset in the cycle after a read ack
        cpu_req = 1'b1; cpu_addr = 16'h0007;
        smp();
        chk("rr_ack", 32'(cpu_ack), 32'd1);
        nxt();
        cpu_req = 1'b0; rst_n = 1'b0;
        smp();
        chk("rr_rvalid_in_rst", 32'(cpu_rvalid), 32'd0);
        nxt();
        rst_n = 1'b1;
        smp();
        chk("rr_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("rr_rdata", 32'(cpu_rdata), 32'd0);
        chk("rr_spr_din", 32'(spr_din), 32'd0);
        nxt();
        cpu_req = 1'b1;
        smp();
        chk("rr_idle_ack", 32'(cpu_ack), 32'd1);
        nxt();
        cpu_req = 1'b0;
        smp();
        chk("rr_rdata_after", 32'(cpu_rdata), 32'h17);
        nxt();

        // Randomized traffic, checked by the model every cycle
        ack_seen = 0;
        vb_left = 5;
        for (int n = 0; n < 4000; n++) begin
            if (ack_seen) begin
                cpu_req = 1'b0;
            end else if (!cpu_req && $urandom_range(0, 2) == 0) begin
                cpu_req = 1'b1;
                cpu_we = 1'($urandom_range(0, 1));
                cpu_addr = rand_addr();
                cpu_wdata = 8'($urandom);
            end
            spr_rd_en = ($urandom_range(0, 9) < 4);
            spr_addr = rand_addr();
            if (vb_left == 0) begin
                vblank = ~vblank;
                vb_left = $urandom_range(1, 20);
            end else begin
                vb_left--;
            end
            rst_n = ($urandom_range(0, 299) != 0);
            smp();
            ack_seen = cpu_ack;
            nxt();
        end

        rst_n = 1'b1; cpu_req = 1'b0; spr_rd_en = 1'b0; vblank = 1'b0;
        repeat (3) nxt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
